axis_splitter_n: RTL and testbench

AXIS_SPLITTER_N -- requirements
Module: axis_splitter_n

---
 rtl/axis_split_pkg.sv | 29 ++
 rtl/axis_lane_fifo.sv | 70 +++++++
 rtl/axis_splitter_n.sv | 89 ++++++++
 tb/tb_axis_splitter_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_split_pkg.sv
// Shared defaults, legal ranges and packet-tracker state encoding for the
// AXI-Stream lane splitter.
package axis_split_pkg;

    localparam int LANE_W_DEF  = 16;
    localparam int N_LANES_DEF = 2;
    localparam int DEPTH_DEF   = 4;

    localparam int N_LANES_MIN = 1;
    localparam int N_LANES_MAX = 8;
    localparam int DEPTH_MIN   = 2;

    typedef logic [0:0] trk_state_t;

    // state   | meaning
    // IDLE    | between packets, next accepted beat is a packet start
    // PKT     | inside a packet, lane mask frozen in act_mask
    localparam trk_state_t ST_IDLE = 1'b0;
    localparam trk_state_t ST_PKT  = 1'b1;

    function automatic bit depth_legal(input int d);
        return (d >= DEPTH_MIN) && ((d & (d - 1)) == 0);
    endfunction

    function automatic bit lanes_legal(input int n);
        return (n >= N_LANES_MIN) && (n <= N_LANES_MAX);
    endfunction

endpackage

// File: rtl/axis_lane_fifo.sv
// Single-lane synchronous FIFO with a flop-based store; the head entry is
// presented directly from the store so a pushed beat is visible next cycle.
module axis_lane_fifo
    import axis_split_pkg::*;
#(
    parameter int W     = LANE_W_DEF + 1,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    assign full_o  = (count_q == DEPTH_C);
    assign valid_o = rst_n_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign pop     = valid_o && ready_i;

    // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axis_splitter_n.sv
// Splits a wide AXI-Stream into N independently handshaken lanes, each
// buffered by its own FIFO; the lane mask is frozen for the length of a packet.
module axis_splitter_n
    import axis_split_pkg::*;
#(
    parameter int LANE_W  = LANE_W_DEF,
    parameter int N_LANES = N_LANES_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_LANES*LANE_W-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [N_LANES-1:0]        lane_en,
    output logic [N_LANES*LANE_W-1:0] m_axis_tdata,
    output logic [N_LANES-1:0]        m_axis_tvalid,
    input  logic [N_LANES-1:0]        m_axis_tready,
    output logic [N_LANES-1:0]        m_axis_tlast
);

    trk_state_t         state_q, state_d;
    logic [N_LANES-1:0] act_mask_q, act_mask_d;
    logic [N_LANES-1:0] mask;
    logic [N_LANES-1:0] full;
    logic [N_LANES-1:0] push;
    logic               s_accept;

    assign mask = (state_q == ST_PKT) ? act_mask_q : lane_en;

    // Only registered fullness feeds tready, so a lane being drained this
    // cycle still blocks the input.
    assign s_axis_tready = aresetn && (&(~mask | ~full));
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d    = state_q;
        act_mask_d = act_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (s_accept && !s_axis_tlast) begin
                    state_d    = ST_PKT;
                    act_mask_d = lane_en;
                end
            end
            ST_PKT: begin
                if (s_accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            act_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            act_mask_q <= act_mask_d;
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [LANE_W:0] lane_dout;

        assign push[i] = s_accept && mask[i];

        axis_lane_fifo #(
            .W     (LANE_W + 1),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (aclk),
            .rst_n_i (aresetn),
            .push_i  (push[i]),
            .data_i  ({s_axis_tdata[i*LANE_W +: LANE_W], s_axis_tlast}),
            .full_o  (full[i]),
            .ready_i (m_axis_tready[i]),
            .valid_o (m_axis_tvalid[i]),
            .data_o  (lane_dout)
        );

        assign m_axis_tdata[i*LANE_W +: LANE_W] = lane_dout[LANE_W:1];
        assign m_axis_tlast[i]                  = lane_dout[0];
    end

endmodule

// File: tb/tb_axis_splitter_n.sv
// Bench for axis_splitter_n: directed vector table and skew sequence on the
// default build, randomized scoreboard run on a 4-lane 8-bit depth-2 build.
module tb_axis_splitter_n;

    logic aclk;
    int   n_total = 0;
    int   n_pass  = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // default build: LANE_W=16, N_LANES=2, DEPTH=4
    logic        a_rst;
    logic [31:0] a_tdata;
    logic        a_tvalid, a_srdy, a_tlast;
    logic [1:0]  a_en;
    logic [31:0] a_mdata;
    logic [1:0]  a_mvalid, a_mrdy, a_mlast;

    axis_splitter_n u_dut_a (
        .aclk          (aclk),
        .aresetn       (a_rst),
        .s_axis_tdata  (a_tdata),
        .s_axis_tvalid (a_tvalid),
        .s_axis_tready (a_srdy),
        .s_axis_tlast  (a_tlast),
        .lane_en       (a_en),
        .m_axis_tdata  (a_mdata),
        .m_axis_tvalid (a_mvalid),
        .m_axis_tready (a_mrdy),
        .m_axis_tlast  (a_mlast)
    );

    // sweep build: LANE_W=8, N_LANES=4, DEPTH=2
    logic        b_rst;
    logic [31:0] b_tdata;
    logic        b_tvalid, b_srdy, b_tlast;
    logic [3:0]  b_en;
    logic [31:0] b_mdata;
    logic [3:0]  b_mvalid, b_mrdy, b_mlast;

    axis_splitter_n #(.LANE_W(8), .N_LANES(4), .DEPTH(2)) u_dut_b (
        .aclk          (aclk),
        .aresetn       (b_rst),
        .s_axis_tdata  (b_tdata),
        .s_axis_tvalid (b_tvalid),
        .s_axis_tready (b_srdy),
        .s_axis_tlast  (b_tlast),
        .lane_en       (b_en),
        .m_axis_tdata  (b_mdata),
        .m_axis_tvalid (b_mvalid),
        .m_axis_tready (b_mrdy),
        .m_axis_tlast  (b_mlast)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic        rst_n;
        logic [31:0] data;
        logic        tvalid;
        logic        tlast;
        logic [1:0]  en;
        logic [1:0]  mrdy;
        logic        exp_srdy;
        logic [1:0]  exp_mvalid;
        logic [31:0] exp_mdata;
        logic [1:0]  exp_mlast;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] d, input logic tv, input logic tl,
                       input logic [1:0] en, input logic [1:0] mr, input logic esr,
                       input logic [1:0] emv, input logic [31:0] emd, input logic [1:0] eml);
        vec_t v;
        v.rst_n = r; v.data = d; v.tvalid = tv; v.tlast = tl; v.en = en; v.mrdy = mr;
        v.exp_srdy = esr; v.exp_mvalid = emv; v.exp_mdata = emd; v.exp_mlast = eml;
        vecs.push_back(v);
    endtask

    logic [16:0] rx [2][$];
    logic [8:0]  mq [4][$];
    logic        first_beat;
    logic [3:0]  held_mask;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          idx;
        logic [3:0]  m_mask;
        logic        exp_srdy;
        logic        exp_v;
        logic [16:0] exp_beat;

        a_rst = 0; a_tdata = '0; a_tvalid = 0; a_tlast = 0; a_en = '0; a_mrdy = '0;
        b_rst = 0; b_tdata = '0; b_tvalid = 0; b_tlast = 0; b_en = '0; b_mrdy = '0;

        // rst data tv tl en mrdy | srdy mvalid mdata mlast
        add(0, 32'h0,         0, 0, 2'b11, 2'b11, 0, 2'b00, 32'h0,         2'b00);
        add(0, 32'h0,         0, 0, 2'b11, 2'b11, 0, 2'b00, 32'h0,         2'b00);
        add(1, 32'hBBBB_AAAA, 1, 0, 2'b11, 2'b11, 1, 2'b00, 32'h0,         2'b00);
        add(1, 32'hDDDD_CCCC, 1, 1, 2'b11, 2'b11, 1, 2'b11, 32'hBBBB_AAAA, 2'b00);
        add(1, 32'h0,         0, 0, 2'b11, 2'b11, 1, 2'b11, 32'hDDDD_CCCC, 2'b11);
        add(1, 32'h0,         0, 0, 2'b11, 2'b11, 1, 2'b00, 32'h0,         2'b00);
        add(1, 32'h2222_1111, 1, 0, 2'b01, 2'b11, 1, 2'b00, 32'h0,         2'b00);
        add(1, 32'h4444_3333, 1, 1, 2'b11, 2'b11, 1, 2'b01, 32'h0000_1111, 2'b00);
        add(1, 32'h6666_5555, 1, 1, 2'b11, 2'b11, 1, 2'b01, 32'h0000_3333, 2'b01);
        add(1, 32'h0,         0, 0, 2'b11, 2'b11, 1, 2'b11, 32'h6666_5555, 2'b11);
        add(1, 32'h0,         0, 0, 2'b11, 2'b11, 1, 2'b00, 32'h0,         2'b00);
        for (int k = 0; k < 5; k++)
            add(1, 32'h0F0F_0E0E, 1, (k == 4), 2'b00, 2'b11, 1, 2'b00, 32'h0, 2'b00);
        add(1, 32'h0,         0, 0, 2'b11, 2'b11, 1, 2'b00, 32'h0,         2'b00);
        add(1, 32'hA1A1_A0A0, 1, 0, 2'b11, 2'b00, 1, 2'b00, 32'h0,         2'b00);
        add(1, 32'hB1B1_B0B0, 1, 0, 2'b11, 2'b00, 1, 2'b11, 32'hA1A1_A0A0, 2'b00);
        add(1, 32'hC1C1_C0C0, 1, 0, 2'b11, 2'b00, 1, 2'b11, 32'hA1A1_A0A0, 2'b00);
        add(0, 32'h0,         0, 0, 2'b11, 2'b00, 0, 2'b00, 32'h0,         2'b00);
        add(1, 32'hD1D1_D0D0, 1, 1, 2'b10, 2'b11, 1, 2'b00, 32'h0,         2'b00);
        add(1, 32'h0,         0, 0, 2'b10, 2'b11, 1, 2'b10, 32'hD1D1_0000, 2'b10);
        add(1, 32'h0,         0, 0, 2'b10, 2'b11, 1, 2'b00, 32'h0,         2'b00);

        foreach (vecs[n]) begin
            @(negedge aclk);
            a_rst = vecs[n].rst_n; a_tdata = vecs[n].data; a_tvalid = vecs[n].tvalid;
            a_tlast = vecs[n].tlast; a_en = vecs[n].en; a_mrdy = vecs[n].mrdy;
            #1;
            chk($sformatf("vec%0d_srdy", n), a_srdy, vecs[n].exp_srdy);
            chk($sformatf("vec%0d_mvalid", n), a_mvalid, vecs[n].exp_mvalid);
            for (int l = 0; l < 2; l++) begin
                if (vecs[n].exp_mvalid[l]) begin
                    chk($sformatf("vec%0d_data%0d", n, l), a_mdata[l*16 +: 16],
                        vecs[n].exp_mdata[l*16 +: 16]);
                    chk($sformatf("vec%0d_last%0d", n, l), a_mlast[l], vecs[n].exp_mlast[l]);
                end
            end
        end

        // skew: lane1 blocked for 6 cycles while 8 beats are offered
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge aclk);
            a_en     = 2'b11;
            a_tvalid = (idx < 8);
            a_tdata  = {16'h0200 + 16'(idx), 16'h0100 + 16'(idx)};
            a_tlast  = (idx == 7);
            a_mrdy   = {(cyc >= 6), 1'b1};
            #1;
            if (cyc <= 6)
                chk($sformatf("skew_srdy_c%0d", cyc), a_srdy, (cyc < 6) ? (idx < 4) : 1'b0);
            for (int l = 0; l < 2; l++)
                if (a_mvalid[l] && a_mrdy[l])
                    rx[l].push_back({a_mdata[l*16 +: 16], a_mlast[l]});
            if (a_tvalid && a_srdy) idx++;
        end
        a_tvalid = 0;
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("skew_count%0d", l), rx[l].size(), 8);
            for (int k = 0; k < 8; k++) begin
                exp_beat = {16'(16'h0100 * (l + 1)) + 16'(k), (k == 7)};
                if (k < rx[l].size())
                    chk($sformatf("skew_beat%0d_%0d", l, k), rx[l][k], exp_beat);
            end
        end

        // randomized run on the sweep build against a packet-level model
        @(negedge aclk); b_rst = 0;
        @(negedge aclk); b_rst = 0;
        first_beat = 1'b1;
        held_mask  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge aclk);
            b_rst    = 1;
            b_tvalid = ($urandom_range(0, 3) != 0);
            b_tdata  = $urandom;
            b_tlast  = ($urandom_range(0, 3) == 0);
            b_en     = 4'($urandom_range(0, 15));
            b_mrdy   = 4'($urandom_range(0, 15));
            #1;
            m_mask   = first_beat ? b_en : held_mask;
            exp_srdy = 1'b1;
            for (int l = 0; l < 4; l++)
                if (m_mask[l] && mq[l].size() >= 2) exp_srdy = 1'b0;
            chk("rnd_srdy", b_srdy, exp_srdy);
            for (int l = 0; l < 4; l++) begin
                exp_v = (mq[l].size() != 0);
                chk($sformatf("rnd_valid%0d", l), b_mvalid[l], exp_v);
                if (exp_v) begin
                    chk($sformatf("rnd_beat%0d", l), {b_mdata[l*8 +: 8], b_mlast[l]}, mq[l][0]);
                    if (b_mrdy[l]) void'(mq[l].pop_front());
                end
            end
            if (b_tvalid && exp_srdy) begin
                if (first_beat) held_mask = b_en;
                for (int l = 0; l < 4; l++)
                    if (m_mask[l]) mq[l].push_back({b_tdata[l*8 +: 8], b_tlast});
                first_beat = b_tlast;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
